// File: rtl/hc138_pkg.sv
// Shared definitions for the 74HC138 chip-select arbiter: state encoding,
// decoder enable constants and requester geometry.
package hc138_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [2:0] EN_ON  = 3'b111;
  localparam logic [2:0] EN_OFF = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_RECOVER
  } state_e;

endpackage

// File: rtl/hc138_rr_pick.sv
// Combinational round-robin search: first set bit of req starting at ptr+1,
// wrapping 7->0, with ptr itself examined last.
module hc138_rr_pick
  import hc138_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos;

  // Scan the eight positions after ptr; the 3-bit add provides the wrap.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = ptr + IDX_W'(k);
      if (!valid && req[pos]) begin
        idx   = pos;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hc138_cs_arbiter.sv
// Round-robin chip-select arbiter driving a 3-to-8 decoder: address setup,
// bounded enable window, dead gap after release. All outputs registered.
// Optional forced release after MAX_HOLD cycles: define HC138_ARB_TIMEOUT_EN.
module hc138_cs_arbiter
  import hc138_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned MIN_HOLD  = 2,
  parameter int unsigned GAP_CYC   = 1,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] sel,
  output logic [2:0]       en,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             tmo
);

`ifdef HC138_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [7:0] SETUP_LAST = (SETUP_CYC > 0) ? 8'(SETUP_CYC - 1) : 8'd0;
  localparam logic [7:0] HOLD_LAST  = (MIN_HOLD  > 0) ? 8'(MIN_HOLD  - 1) : 8'd0;
  localparam logic [7:0] GAP_LAST   = (GAP_CYC   > 0) ? 8'(GAP_CYC   - 1) : 8'd0;
  localparam logic [7:0] MAX_LAST   = (MAX_HOLD  > 0) ? 8'(MAX_HOLD  - 1) : 8'd0;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [2:0]       en_q, en_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [7:0]       cnt_inc;
  logic             go_active;
  logic             go_release;
  logic [IDX_W-1:0] grant_idx;

  hc138_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state and next-output logic; grant entry and release are shared
  // actions reached from several states, so they are applied after the case.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    en_d       = en_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    tmo_d      = 1'b0;
    cnt_d      = cnt_q;
    go_active  = 1'b0;
    go_release = 1'b0;
    grant_idx  = sel_q;
    cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        en_d   = EN_OFF;
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_valid) begin
          sel_d  = pick_idx;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (SETUP_CYC == 0) begin
            go_active = 1'b1;
            grant_idx = pick_idx;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (!req[sel_q]) begin
          go_release = 1'b1;
        end else if (cnt_q >= SETUP_LAST) begin
          go_active = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q >= HOLD_LAST && !req[sel_q]) begin
          go_release = 1'b1;
        end else if (TMO_EN && cnt_q >= MAX_LAST) begin
          go_release = 1'b1;
          tmo_d      = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RECOVER: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = EN_OFF;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    if (go_active) begin
      state_d = ST_ACTIVE;
      sel_d   = grant_idx;
      ptr_d   = grant_idx;
      en_d    = EN_ON;
      gnt_d   = N_REQ'(1) << grant_idx;
      cnt_d   = '0;
    end

    if (go_release) begin
      en_d  = EN_OFF;
      gnt_d = '0;
      cnt_d = '0;
      if (GAP_CYC == 0) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d = ST_RECOVER;
      end
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= 3'd7;
      en_q    <= EN_OFF;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_hc138_cs_arbiter.sv
// Self-checking bench for hc138_cs_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model. Honours HC138_ARB_TIMEOUT_EN when defined.
module tb_hc138_cs_arbiter;

  localparam int unsigned SETUP_CYC = 1;
  localparam int unsigned MIN_HOLD  = 2;
  localparam int unsigned GAP_CYC   = 1;
  localparam int unsigned MAX_HOLD  = 16;
`ifdef HC138_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_SETUP = 1, P_ACTIVE = 2, P_RECOVER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [2:0] sel;
  logic [2:0] en;
  logic [7:0] gnt;
  logic       busy;
  logic       tmo;

  always #5 clk = ~clk;

  hc138_cs_arbiter #(
    .SETUP_CYC (SETUP_CYC),
    .MIN_HOLD  (MIN_HOLD),
    .GAP_CYC   (GAP_CYC),
    .MAX_HOLD  (MAX_HOLD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .sel  (sel),
    .en   (en),
    .gnt  (gnt),
    .busy (busy),
    .tmo  (tmo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = P_IDLE;
  int m_age   = 0;   // cycles completed in the current phase
  int m_owner = 0;   // requester currently addressed (sel)
  int m_last  = 7;   // last requester that actually received en=111
  bit m_tmo   = 1'b0;
  bit started = 1'b0;

  function automatic int rr_winner(input logic [7:0] r, input int last);
    for (int d = 1; d <= 8; d++) begin
      if (r[(last + d) % 8]) return (last + d) % 8;
    end
    return -1;
  endfunction

  task automatic m_finish();
    m_age = 0;
    m_phase = (GAP_CYC == 0) ? P_IDLE : P_RECOVER;
  endtask

  task automatic m_step(input logic [7:0] r);
    int w;
    m_tmo = 1'b0;
    case (m_phase)
      P_IDLE: begin
        w = rr_winner(r, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_age   = 0;
          if (SETUP_CYC == 0) begin m_phase = P_ACTIVE; m_last = w; end
          else m_phase = P_SETUP;
        end
      end
      P_SETUP: begin
        m_age++;
        if (!r[m_owner]) m_finish();
        else if (m_age >= int'(SETUP_CYC)) begin
          m_phase = P_ACTIVE; m_last = m_owner; m_age = 0;
        end
      end
      P_ACTIVE: begin
        m_age++;
        if (m_age >= int'(MIN_HOLD) && !r[m_owner]) m_finish();
        else if (TMO_EN && m_age >= int'(MAX_HOLD)) begin m_finish(); m_tmo = 1'b1; end
      end
      default: begin
        m_age++;
        if (m_age >= int'(GAP_CYC)) begin m_phase = P_IDLE; m_age = 0; end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = P_IDLE; m_age = 0; m_owner = 0; m_last = 7; m_tmo = 1'b0;
      started = 1'b1;
    end else begin
      m_step(req);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_sel",  sel,  m_owner);
      chk("m_en",   en,   (m_phase == P_ACTIVE) ? 7 : 0);
      chk("m_gnt",  gnt,  (m_phase == P_ACTIVE) ? (1 << m_owner) : 0);
      chk("m_busy", busy, (m_phase != P_IDLE) ? 1 : 0);
      chk("m_tmo",  tmo,  m_tmo);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    rst = 1'b1; req = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic wait_en();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (en == 3'b111) begin ok = 1'b1; break; end
    end
    chk("en_reached", ok, 1);
  endtask

  initial begin
    int cnt;
    int first_tmo;
    int act_len;
    bit tmo19;
    int en21, sel21;
    logic [7:0] flip;

    do_reset();

    // Reset / idle
    repeat (10) begin
      @(negedge clk);
      chk("idle_sel", sel, 0); chk("idle_en", en, 0);
      chk("idle_gnt", gnt, 0); chk("idle_busy", busy, 0);
    end

    // Single request
    req = 8'h10;
    @(negedge clk);
    chk("single_sel", sel, 4); chk("single_busy_setup", busy, 1); chk("single_en_setup", en, 0);
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk);
      chk("single_en", en, 7); chk("single_gnt", gnt, 8'h10);
      if (j == 5) req = 8'h00;
    end
    @(negedge clk);
    chk("single_en_recover", en, 0); chk("single_busy_recover", busy, 1);
    @(negedge clk);
    chk("single_busy_idle", busy, 0);

    // MIN_HOLD: request falls in the first ACTIVE cycle
    req = 8'h02;
    @(negedge clk);
    @(negedge clk);
    req = 8'h00;
    cnt = (en == 3'b111) ? 1 : 0;
    repeat (7) begin
      @(negedge clk);
      if (en == 3'b111) cnt++;
    end
    chk("min_hold_len", cnt, 2);

    // SETUP abort leaves the pointer untouched
    do_reset();
    req = 8'h08;
    @(negedge clk);
    chk("abort_sel", sel, 3); chk("abort_busy", busy, 1); chk("abort_en", en, 0);
    req = 8'h00;
    @(negedge clk);
    chk("abort_recover_en", en, 0); chk("abort_recover_busy", busy, 1);
    @(negedge clk);
    chk("abort_idle", busy, 0);
    req = 8'h88;
    @(negedge clk);
    chk("abort_ptr_sel", sel, 3);
    req = 8'h00;
    wait_idle();

    // Round-robin fairness with two persistent requesters
    do_reset();
    req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      wait_en();
      chk("rr_grant", sel, (g % 2 == 1) ? 7 : 0);
      req = req & ~(8'h01 << sel);
      wait_idle();
      req = 8'h81;
    end
    req = 8'h00;
    wait_idle();

    // Reset in the middle of ACTIVE
    req = 8'h04;
    wait_en();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_en", en, 0); chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0); chk("midrst_sel", sel, 0);
    rst = 1'b0; req = 8'h00;
    @(negedge clk);

`ifdef HC138_ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles
    do_reset();
    req = 8'h01;
    first_tmo = -1; act_len = 0; tmo19 = 1'b0; en21 = 0; sel21 = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (first_tmo < 0 && en == 3'b111) act_len++;
      if (first_tmo < 0 && tmo) first_tmo = j;
      if (j == 19) tmo19 = tmo;
      if (j == 21) begin en21 = en; sel21 = sel; end
    end
    chk("tmo_active_len", act_len, 16);
    chk("tmo_first_cycle", first_tmo, 18);
    chk("tmo_one_cycle", tmo19, 0);
    chk("tmo_regrant_en", en21, 7);
    chk("tmo_regrant_sel", sel21, 0);
    req = 8'h00;
    wait_idle();
`else
    first_tmo = 0; act_len = 0; tmo19 = 1'b0; en21 = 0; sel21 = 0;
`endif

    // Randomized traffic, model compared every cycle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if (c >= 1500 && c < 2000) req = req & 8'($urandom);
      else req = req ^ flip;
    end
    rst = 1'b0; req = 8'h00;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hc138_cs_arbiter.md
Name: hc138_cs_arbiter

Overview:
- Sequential controller that drives a 3-to-8 chip-select decoder (3-bit select, 3-bit all-ones enable, 8-bit one-hot output) on behalf of up to 8 requesters.
- Arbitrates requests round-robin, holds the select address stable before asserting enable, keeps enable for a bounded window, then enforces a dead gap before the next grant.
- Sits between the CPU-side bus requesters and the decoder; the decoder's enable/select inputs connect directly to this block's en/sel outputs.

Parameters:
- SETUP_CYC, 1, cycles sel is stable with en=3'b000 before enable (0..255; 0 skips SETUP).
- MIN_HOLD, 2, minimum cycles en=3'b111 stays asserted once granted (1..255).
- GAP_CYC, 1, dead cycles with en=3'b000 after release (0..255; 0 skips RECOVER).
- MAX_HOLD, 16, forced release limit; used only with the optional feature (must be >= MIN_HOLD, <= 255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  level request per requester; bit i = requester i.
- sel  output 3  decoder select (index of granted requester).
- en  output 3  decoder enable; 3'b111 only in ACTIVE, otherwise 3'b000.
- gnt  output 8  one-hot grant mirror (8'b1 << sel in ACTIVE, else 0).
- busy  output 1  high in any state other than IDLE.
- tmo  output 1  one-cycle pulse on forced release (always 0 without the feature).

Behaviour:
- Synchronous, active-high reset on rst, single clock clk. All outputs are registered.
- Reset values: sel=3'b000, en=3'b000, gnt=8'h00, busy=0, tmo=0, state=IDLE, rr pointer=3'd7 (first search starts at 0), counter=0.
- States:
  - IDLE: if req!=0, the winner is the first set bit searching from ptr+1 upward, wrapping 7->0. Latch winner into sel; busy=1. Go to SETUP, or to ACTIVE if SETUP_CYC=0. If req==0, stay.
  - SETUP: en=000. Counts SETUP_CYC cycles. If req[sel] drops before the count completes, abort to RECOVER (no grant, ptr unchanged). Otherwise go to ACTIVE.
  - ACTIVE: en=111, gnt=1<<sel. On entry, ptr<=sel and counter<=0. Leave to RECOVER when counter>=MIN_HOLD-1 and req[sel]==0. A request drop before MIN_HOLD is ignored; the grant is held until MIN_HOLD completes.
  - RECOVER: en=000, gnt=0. Counts GAP_CYC cycles, then goes to IDLE (busy=0 in IDLE). If GAP_CYC=0, go to IDLE directly.
- Latency (defaults): req rises in cycle N in IDLE -> sel valid at N+1 -> en=111 at N+2. After release, the next grant's sel is valid no earlier than 1+GAP_CYC+1 cycles later.
- Counter: 8 bits, saturating; it never wraps.
- Simultaneous requests: round-robin only. A requester that holds req continuously cannot win twice while another requester is pending.
- Requests arriving during SETUP, ACTIVE or RECOVER are not latched; only levels sampled in IDLE count.
- sel changes only on the IDLE->SETUP/ACTIVE transition. sel is never changed while en=111.
- rst mid-operation: the next cycle shows reset values; en drops to 000 immediately at that edge.

Optional Feature:
- Macro: HC138_ARB_TIMEOUT_EN.
- Defined: in ACTIVE, when counter reaches MAX_HOLD-1 with req[sel] still high, force a transition to RECOVER. tmo pulses high for exactly one cycle, coincident with the first RECOVER cycle.
- Not defined: ACTIVE persists while req[sel] is high, with no upper bound. tmo is tied 0 and MAX_HOLD is unused.

Decomposition:
- Shared package hc138_pkg holds:
  - State encoding typedef (IDLE, SETUP, ACTIVE, RECOVER).
  - Constants EN_ON=3'b111 and EN_OFF=3'b000.
  - Requester count 8 and index width 3.
- One natural sub-module: hc138_rr_pick. It is combinational; inputs req[7:0] and ptr[2:0], outputs idx[2:0] and valid. It wraps the round-robin search.

Test Plan:
- Reset/idle: assert rst 2 cycles, req=0 -> sel=0, en=000, gnt=00, busy=0 held for 10 cycles.
- Single request: req=8'h10 at N, dropped at N+5 -> sel=4 at N+1; en=111 and gnt=8'h10 from N+2 through N+5; en=000 at N+6 (RECOVER); busy=0 at N+7.
- Round-robin fairness: req=8'h81 held constantly -> grants alternate 0,7,0,7.
- MIN_HOLD: req=8'h02 pulsed for 1 cycle past SETUP -> en=111 exactly 2 cycles.
- SETUP abort: req=8'h08 for one cycle only -> sel=3 and busy=1, en never 111, RECOVER then IDLE, next grant starts search at 0.
- Timeout (macro defined): req=8'h01 held 40 cycles -> en=111 for 16 cycles, tmo=1 for one cycle, GAP, then regrant to 0. Mid-ACTIVE rst -> en=000 the next cycle.
